// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding at capture, bubble insertion and load-use bubble count.
// Macro ID_EX_FWD_EN enables the operand forwarding muxes; without it operands come straight from the register file.
module id_ex_stage #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              load_use,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [31:0]       id_ir,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       id_r1,
   input  logic [31:0]       id_r2,
   input  logic [31:0]       id_imm,
   input  logic [4:0]        id_shamt,
   input  logic [4:0]        id_wreg,
   input  logic [1:0]        r1_fwd_sel,
   input  logic [1:0]        r2_fwd_sel,
   input  logic [31:0]       mem_fwd_data,
   input  logic [31:0]       wb_fwd_data,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_ir,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_r1,
   output logic [31:0]       ex_r2,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_shamt,
   output logic [4:0]        ex_wreg,
   output logic [CNT_W-1:0]  bubble_num
);
   logic [31:0] r1_in, r2_in;
   logic        zero, bump;
`ifdef ID_EX_FWD_EN
   always_comb begin
      r1_in = r1_fwd_sel == 2'b01 ? mem_fwd_data : r1_fwd_sel == 2'b10 ? wb_fwd_data : id_r1;
      r2_in = r2_fwd_sel == 2'b01 ? mem_fwd_data : r2_fwd_sel == 2'b10 ? wb_fwd_data : id_r2;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{r1_fwd_sel, r2_fwd_sel, mem_fwd_data, wb_fwd_data};
   assign r1_in = id_r1;
   assign r2_in = id_r2;
`endif
   // flush overrides stall; a load-use bubble only lands when the stage is not held
   assign zero = rst | flush | (~stall & load_use);
   assign bump = ~flush & ~stall & load_use & ~&bubble_num;
   always_ff @(posedge clk) begin
      if (zero) begin
         ex_valid <= 1'b0;
         ex_pc    <= '0;
         ex_ir    <= '0;
         ex_ctrl  <= '0;
         ex_r1    <= '0;
         ex_r2    <= '0;
         ex_imm   <= '0;
         ex_shamt <= '0;
         ex_wreg  <= '0;
      end else if (!stall) begin
         ex_valid <= id_valid;
         ex_pc    <= id_pc;
         ex_ir    <= id_ir;
         ex_ctrl  <= id_ctrl;
         ex_r1    <= r1_in;
         ex_r2    <= r2_in;
         ex_imm   <= id_imm;
         ex_shamt <= id_shamt;
         ex_wreg  <= id_wreg;
      end
      if (rst) bubble_num <= '0;
      else if (bump) bubble_num <= bubble_num + 1'b1;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; a 2-bit counter instance exercises bubble_num saturation.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 0, stall = 0, flush = 0, load_use = 0, id_valid = 0;
   logic [31:0] id_pc = 0, id_ir = 0, id_r1 = 0, id_r2 = 0, id_imm = 0, mem_fwd_data = 0, wb_fwd_data = 0;
   logic [15:0] id_ctrl = 0;
   logic [4:0]  id_shamt = 0, id_wreg = 0;
   logic [1:0]  r1_fwd_sel = 0, r2_fwd_sel = 0;
   logic        ex_valid, s_valid;
   logic [31:0] ex_pc, ex_ir, ex_r1, ex_r2, ex_imm, s_pc, s_ir, s_r1, s_r2, s_imm;
   logic [15:0] ex_ctrl, s_ctrl;
   logic [4:0]  ex_shamt, ex_wreg, s_shamt, s_wreg;
   logic [31:0] bubble_num;
   logic [1:0]  sat_num;
   int tests = 0, fails = 0;

   typedef struct packed {
      logic [186:0] ex;
      logic [31:0]  cnt;
      logic [1:0]   sat;
   } e_t;
   e_t q[$];
   e_t m = '0;

   always #5 clk = ~clk;

   id_ex_stage #(.CTRL_W(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .load_use(load_use), .id_valid(id_valid),
      .id_pc(id_pc), .id_ir(id_ir), .id_ctrl(id_ctrl), .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_wreg(id_wreg), .r1_fwd_sel(r1_fwd_sel), .r2_fwd_sel(r2_fwd_sel),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_ir(ex_ir), .ex_ctrl(ex_ctrl), .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_imm(ex_imm),
      .ex_shamt(ex_shamt), .ex_wreg(ex_wreg), .bubble_num(bubble_num));

   id_ex_stage #(.CTRL_W(16), .CNT_W(2)) sat_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .load_use(load_use), .id_valid(id_valid),
      .id_pc(id_pc), .id_ir(id_ir), .id_ctrl(id_ctrl), .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_wreg(id_wreg), .r1_fwd_sel(r1_fwd_sel), .r2_fwd_sel(r2_fwd_sel),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .ex_valid(s_valid), .ex_pc(s_pc),
      .ex_ir(s_ir), .ex_ctrl(s_ctrl), .ex_r1(s_r1), .ex_r2(s_r2), .ex_imm(s_imm),
      .ex_shamt(s_shamt), .ex_wreg(s_wreg), .bubble_num(sat_num));

   function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] r, md, wd);
`ifdef ID_EX_FWD_EN
      return s == 2'b01 ? md : s == 2'b10 ? wd : r;
`else
      return r;
`endif
   endfunction

   // flags: {rst, stall, flush, load_use}
   task automatic drv(input logic [3:0] f, input logic v, input logic [31:0] pc, ir, input logic [15:0] ct,
                      input logic [31:0] r1, r2, imm, input logic [4:0] sh, wr,
                      input logic [1:0] s1, s2, input logic [31:0] md, wd);
      @(negedge clk);
      #1;
      {rst, stall, flush, load_use} = f;
      id_valid = v; id_pc = pc; id_ir = ir; id_ctrl = ct; id_r1 = r1; id_r2 = r2; id_imm = imm;
      id_shamt = sh; id_wreg = wr; r1_fwd_sel = s1; r2_fwd_sel = s2; mem_fwd_data = md; wb_fwd_data = wd;
      if (f[3]) m = '0;
      else if (f[1]) m.ex = '0;
      else if (f[2]) m = m;
      else if (f[0]) begin
         m.ex = '0;
         if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
         if (m.sat != 2'b11) m.sat = m.sat + 1;
      end else
         m.ex = {v, pc, ir, ct, fsel(s1, r1, md, wd), fsel(s2, r2, md, wd), imm, sh, wr};
      q.push_back(m);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         automatic e_t e = q.pop_front();
         automatic logic [186:0] got = {ex_valid, ex_pc, ex_ir, ex_ctrl, ex_r1, ex_r2, ex_imm, ex_shamt, ex_wreg};
         tests += 3;
         if (got !== e.ex) begin
            fails++;
            $display("FAIL ex_bundle got=%h exp=%h", got, e.ex);
         end
         if (bubble_num !== e.cnt) begin
            fails++;
            $display("FAIL bubble_num got=%h exp=%h", bubble_num, e.cnt);
         end
         if (sat_num !== e.sat) begin
            fails++;
            $display("FAIL sat_bubble_num got=%h exp=%h", sat_num, e.sat);
         end
      end
   end

   initial begin
      drv(4'b1000, 1, 32'h44, 32'hDEAD_BEEF, 16'hFFFF, 9, 9, 9, 5'd9, 5'd9, 2'b01, 2'b10, 32'h11, 32'h22);
      drv(4'b0000, 1, 32'h8, 32'h8C08_0004, 16'h1234, 5, 7, 4, 5'd3, 5'd8, 2'b00, 2'b00, 32'hAA, 32'hBB);
      drv(4'b0000, 1, 32'hC, 32'h0128_5020, 16'h0101, 1, 2, 0, 5'd0, 5'd10, 2'b01, 2'b10, 32'hAA, 32'hBB);
      drv(4'b0000, 1, 32'h10, 32'h0128_5022, 16'h0102, 3, 4, 0, 5'd1, 5'd11, 2'b11, 2'b01, 32'hCC, 32'hDD);
      drv(4'b0000, 0, 32'h14, 32'h2129_0001, 16'h0003, 6, 8, 1, 5'd2, 5'd9, 2'b10, 2'b00, 32'hEE, 32'hFF);
      for (int i = 0; i < 3; i++)
         drv(4'b0001, 1, 32'h18, 32'h0109_5020, 16'h8001, 7, 7, 7, 5'd7, 5'd10, 2'b01, 2'b01, 32'h55, 32'h66);
      drv(4'b0000, 1, 32'h1C, 32'h0109_5020, 16'h8001, 7, 8, 9, 5'd4, 5'd10, 2'b00, 2'b00, 32'h55, 32'h66);
      drv(4'b0011, 1, 32'h20, 32'h1109_0002, 16'h4000, 1, 1, 2, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0);
      drv(4'b0000, 1, 32'h24, 32'hAD09_0008, 16'h2020, 12, 13, 8, 5'd6, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0);
      drv(4'b0100, 1, 32'h28, 32'h1234_5678, 16'h7777, 21, 22, 23, 5'd24, 5'd25, 2'b01, 2'b10, 32'h1, 32'h2);
      drv(4'b0100, 0, 32'h2C, 32'h8765_4321, 16'h5555, 31, 32, 33, 5'd14, 5'd15, 2'b00, 2'b00, 32'h1, 32'h2);
      drv(4'b0101, 1, 32'h30, 32'h0000_1111, 16'h3333, 41, 42, 43, 5'd16, 5'd17, 2'b00, 2'b00, 32'h1, 32'h2);
      drv(4'b0110, 1, 32'h34, 32'h0000_2222, 16'h6666, 51, 52, 53, 5'd18, 5'd19, 2'b00, 2'b00, 32'h1, 32'h2);
      for (int i = 0; i < 3; i++)
         drv(4'b0001, 1, 32'h38, 32'h0000_3333, 16'h1111, 61, 62, 63, 5'd20, 5'd21, 2'b00, 2'b00, 32'h1, 32'h2);
      drv(4'b0000, 1, 32'h3C, 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
          5'd31, 5'd31, 2'b10, 2'b01, 32'h7FFF_FFFF, 32'h1);
      drv(4'b1100, 1, 32'h40, 32'h0000_4444, 16'h2222, 71, 72, 73, 5'd22, 5'd23, 2'b00, 2'b00, 32'h1, 32'h2);
      drv(4'b0001, 1, 32'h44, 32'h0000_5555, 16'h9999, 81, 82, 83, 5'd24, 5'd25, 2'b00, 2'b00, 32'h1, 32'h2);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage pipelined MIPS CPU.
- Sits directly downstream of the decode logic: register usage, correlation detection and load-use detection.
- Captures the decoded instruction, control bundle, operands, immediate and destination register for the EX stage.
- Applies operand forwarding at capture, inserts bubbles on load-use or flush, holds on halt, and keeps the bubble_num statistic.

Parameters:
- CTRL_W, 16, width of the packed control bundle (RegWrite, MemToReg, MemWrite, AluOP, AluSrcB, JAL, JR, Beq, Bne, B-signal, Syscall, MemAccess).
- CNT_W, 32, width of the bubble statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers (HALT without go).
- flush  in  1  taken branch/jump resolved in EX; next EX content is a bubble.
- load_use  in  1  load-use hazard from decode; next EX content is a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC+4 of ID instruction.
- id_ir  in  32  ID instruction word.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_r1, id_r2  in  32  register-file read data.
- id_imm  in  32  extended immediate.
- id_shamt  in  5  shift amount.
- id_wreg  in  5  destination register number.
- r1_fwd_sel, r2_fwd_sel  in  2  forwarding selects.
- mem_fwd_data  in  32  MEM-stage result.
- wb_fwd_data  in  32  WB-stage result.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_ir  out  32  registered copies.
- ex_ctrl  out  CTRL_W  registered control.
- ex_r1, ex_r2, ex_imm  out  32  registered operands.
- ex_shamt, ex_wreg  out  5  registered fields.
- bubble_num  out  CNT_W  load-use bubble count.

Behaviour:
- All outputs update only on the rising clk edge; one-cycle latency from ID inputs to ex_* outputs.
- Per-edge priority:
  1. rst: all outputs, including bubble_num, set to 0.
  2. flush: bubble loaded.
  3. stall: every register holds, bubble_num holds.
  4. load_use: bubble loaded, bubble_num increments.
  5. Otherwise: normal capture.
- Bubble: ex_valid, ex_pc, ex_ir, ex_ctrl, ex_r1, ex_r2, ex_imm, ex_shamt, ex_wreg all set to 0. ex_ir = 0 encodes sll $0,$0,0 (a nop); ex_ctrl = 0 means no register write, no memory write, no branch.
- Normal capture:
  - ex_valid <= id_valid.
  - All other fields copied from the ID inputs.
  - ex_r1 and ex_r2 taken through the forwarding select.
- Forwarding select (applies to each operand independently): 00 -> id_rN; 01 -> mem_fwd_data; 10 -> wb_fwd_data; 11 -> id_rN (reserved).
- When both MEM and WB would match, upstream logic drives 01; MEM has priority and this block does not arbitrate.
- flush and load_use in the same cycle: one bubble; bubble_num does not increment (flush wins).
- stall and load_use in the same cycle: hold; no increment.
- rst while stall is high: rst wins.
- bubble_num saturates at all-ones; it never wraps.
- A bubble must leave ex_wreg = 0 and RegWrite = 0, so the correlation detector never sees a false EX dependence.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding muxes present as described above.
- Undefined:
  - r1_fwd_sel, r2_fwd_sel, mem_fwd_data and wb_fwd_data are ignored.
  - ex_r1 <= id_r1 and ex_r2 <= id_r2 on capture.
  - The CPU resolves all data hazards by stalling.
- Port list is identical in both builds.

Test Plan:
- Reset: rst=1 one cycle with nonzero inputs -> all ex_* = 0 and bubble_num = 0 after the edge.
- Normal capture: id_valid=1, id_ir=0x8C080004, id_pc=0x00000008, id_r1=5, sel=00 -> next cycle ex_ir=0x8C080004, ex_pc=8, ex_r1=5, ex_valid=1.
- Forwarding: id_r1=1, mem_fwd_data=0xAA, wb_fwd_data=0xBB, r1_fwd_sel=01, r2_fwd_sel=10 -> ex_r1=0xAA, ex_r2=0xBB. With ID_EX_FWD_EN undefined -> ex_r1=1.
- Load-use: load_use=1 for 3 cycles -> ex_valid=0, ex_ctrl=0, ex_wreg=0 each cycle; bubble_num 0 -> 3.
- Simultaneous events:
  - flush=1 with load_use=1 -> bubble, bubble_num unchanged.
  - stall=1 with new inputs -> ex_* hold previous values for all stalled cycles.
- Saturation: force bubble_num to 0xFFFFFFFE, then 3 load_use cycles -> 0xFFFFFFFF, stays there.
